tgif_mask_sched: RTL
====================

Name: tgif_mask_sched

Overview:
- Mask-sequencing stage that sits directly upstream of the tweakable-block-cipher datapath in the TGIF AEAD core.
- It loads an initial 128-bit mask from the key/nonce setup path, then presents one mask per block to the cipher over a valid/ready handshake.
- After each accepted mask it advances to the next mask: remove the old domain byte, double in GF(2^128) in the TGIF byte order, insert the new domain byte.
- It also counts blocks and flags overflow of the permitted message length.

Parameters:
- CNT_W, 32: width of the block counter.
- MAX_BLOCKS, 32'hFFFF_FFFF: number of masks that may be issued per init before the error is raised.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- init_valid  input  1  initial mask offered.
- init_ready  output  1  block can accept an init.
- init_mask  input  128  initial mask, domain-free.
- init_dom  input  8  domain byte for the first mask.
- step_dom  input  8  domain byte applied when the current mask is accepted; sampled at the out handshake.
- stop  input  1  end of message; return to IDLE.
- out_valid  output  1  out_mask/out_dom valid.
- out_ready  input  1  cipher consumes the mask.
- out_mask  output  128  current mask, domain included.
- out_dom  output  8  domain byte currently inside out_mask.
- blk_cnt  output  CNT_W  masks accepted since the last init.
- err  output  1  sticky block-count overflow.

Behaviour:
- Reset: state IDLE; out_valid=0; out_mask=0; out_dom=0; blk_cnt=0; err=0; init_ready=1.
- States are IDLE, RUN and ERR. init_ready=1 in IDLE and ERR, 0 in RUN.
- IDLE/ERR, init handshake:
  - out_mask <= init_mask ^ {120'h0, init_dom}; out_dom <= init_dom; blk_cnt <= 0; err <= 0.
  - Go to RUN; out_valid=1 on the next cycle.
- RUN: out_valid=1 and is held until out_ready.
  - out_mask and out_dom are stable while out_valid=1 and out_ready=0.
- Out handshake in RUN: on the next cycle out_mask <= D(out_mask, out_dom, step_dom), out_dom <= step_dom, blk_cnt+1. Throughput is one mask per cycle, with no bubble.
- D(s, dold, dnew) is defined byte-wise, with byte i = s[8i+7:8i]:
  1. Form L = {s.byte0^dold, s.byte1, ..., s.byte15}, so L[127:120] = byte0 ^ dold.
  2. Compute L' = {L[126:0], L[127]} ^ ({L[127]} at bits 7, 2 and 1), i.e. doubling modulo x^128 + x^7 + x^2 + x + 1.
  3. Output = {L'[7:0], L'[15:8], ..., L'[127:120] ^ dnew}, so the output byte0 = L'[127:120] ^ dnew.
- Overflow: a handshake that makes blk_cnt equal MAX_BLOCKS sets err=1, moves to ERR and drops out_valid the next cycle. err stays set until the next init handshake or rst.
- stop in RUN:
  - Go to IDLE next cycle with out_valid=0.
  - If a handshake occurs in the same cycle, it is counted and the mask is advanced; the advanced mask is not offered.
  - stop is ignored in IDLE and ERR.
- init_valid in RUN is ignored (init_ready=0).
- rst is synchronous and overrides everything in the same edge, including mid-run.

Decomposition:
- Shared package tgif_pkg holds:
  - MASK_W=128, DOM_W=8;
  - the reduction constant 8'h87;
  - the state enum {IDLE, RUN, ERR};
  - the team's domain-byte constants.
- One combinational sub-module, tgif_mask_step (s, dold, dnew -> so), implements D. The FSM, registers and counter stay in the top.

Test Plan:
- init_mask=128'h01, init_dom=0, step_dom=0, out_ready=1 -> first out_mask=128'h01, next out_mask=128'h02, blk_cnt=1.
- init_mask=128'h80, dom 0, one handshake -> out_mask=128'h8700_0000_0000_0000_0000_0000_0000_0000 (carry reduction into the top byte).
- init_mask=0, init_dom=8'h20, step_dom=8'h21, handshake -> out_mask=128'h21, out_dom=8'h21 (old domain removed, new inserted).
- Hold out_ready=0 for 5 cycles -> out_valid=1, out_mask unchanged, blk_cnt unchanged. Then out_ready=1 for 3 cycles -> three distinct masks, blk_cnt=3.
- MAX_BLOCKS=4, out_ready=1:
  - after the 4th handshake: err=1, out_valid=0, init_ready=1;
  - a new init then clears err and sets blk_cnt=0.
- stop asserted together with a handshake -> blk_cnt increments, next cycle IDLE, out_valid=0.
- rst mid-RUN -> all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/tgif_pkg.sv
// Shared types and constants for the TGIF mask scheduler.
package tgif_pkg;

   localparam int MASK_W = 128;
   localparam int DOM_W  = 8;
   localparam int NBYTES = MASK_W / 8;

   localparam logic [7:0] RED_POLY = 8'h87;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ERR
   } state_t;

   localparam logic [DOM_W-1:0] DOM_NONCE = 8'h10;
   localparam logic [DOM_W-1:0] DOM_AD    = 8'h20;
   localparam logic [DOM_W-1:0] DOM_AD_P  = 8'h21;
   localparam logic [DOM_W-1:0] DOM_MSG   = 8'h40;
   localparam logic [DOM_W-1:0] DOM_MSG_P = 8'h41;
   localparam logic [DOM_W-1:0] DOM_TAG   = 8'h80;

   function automatic logic [MASK_W-1:0] brev
     (input logic [MASK_W-1:0] x);
      logic [MASK_W-1:0] r;
      r = '0;
      for (int i = 0; i < NBYTES; i++)
         r[8*i +: 8] = x[MASK_W-8-8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/tgif_mask_step.sv
// One mask advance: strip old domain, GF(2^128) doubling
// in byte-reversed order, insert new domain.
module tgif_mask_step
   import tgif_pkg::*;
(
   input  logic [MASK_W-1:0] s,
   input  logic [DOM_W-1:0]  dold,
   input  logic [DOM_W-1:0]  dnew,
   output logic [MASK_W-1:0] so
);

   logic [MASK_W-1:0] l;
   logic [MASK_W-1:0] ld;
   logic [7:0]        red;

   // dold lands in the top byte because byte0 is reversed to the top
   assign l   = brev(s) ^ {dold, {(MASK_W-DOM_W){1'b0}}};
   assign red = RED_POLY & {8{l[MASK_W-1]}};
   assign ld  = {l[MASK_W-2:0], 1'b0}
              ^ {{(MASK_W-8){1'b0}}, red};
   assign so  = brev(ld)
              ^ {{(MASK_W-DOM_W){1'b0}}, dnew};

endmodule

// File: rtl/tgif_mask_sched.sv
// Mask sequencer feeding the TGIF tweakable block cipher:
// init load, per-block advance, block counter, overflow flag.
module tgif_mask_sched
   import tgif_pkg::*;
#(
   parameter int             CNT_W      = 32,
   parameter logic [CNT_W-1:0] MAX_BLOCKS = 32'hFFFF_FFFF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              init_valid,
   output logic              init_ready,
   input  logic [MASK_W-1:0] init_mask,
   input  logic [DOM_W-1:0]  init_dom,
   input  logic [DOM_W-1:0]  step_dom,
   input  logic              stop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MASK_W-1:0] out_mask,
   output logic [DOM_W-1:0]  out_dom,
   output logic [CNT_W-1:0]  blk_cnt,
   output logic              err
);

   state_t            state;
   state_t            state_n;
   logic              init_hs;
   logic              out_hs;
   logic              ovf;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [MASK_W-1:0] mask_nxt;

   assign init_hs = init_valid & init_ready;
   assign out_hs  = out_valid & out_ready;
   assign cnt_nxt = blk_cnt + CNT_W'(1);
   assign ovf     = out_hs && (cnt_nxt == MAX_BLOCKS);

   tgif_mask_step u_step (
      .s    (out_mask),
      .dold (out_dom),
      .dnew (step_dom),
      .so   (mask_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n    = state;
      init_ready = 1'b1;
      out_valid  = 1'b0;
      unique case (state)
         IDLE, ERR: begin
            if (init_hs)
               state_n = RUN;
         end
         RUN: begin
            init_ready = 1'b0;
            out_valid  = 1'b1;
            // overflow wins over a coincident stop
            if (ovf)
               state_n = ERR;
            else if (stop)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_mask <= '0;
         out_dom  <= '0;
         blk_cnt  <= '0;
         err      <= 1'b0;
      end else if (init_hs) begin
         out_mask <= init_mask
                   ^ {{(MASK_W-DOM_W){1'b0}}, init_dom};
         out_dom  <= init_dom;
         blk_cnt  <= '0;
         err      <= 1'b0;
      end else if (out_hs) begin
         out_mask <= mask_nxt;
         out_dom  <= step_dom;
         blk_cnt  <= cnt_nxt;
         if (ovf)
            err <= 1'b1;
      end
   end

endmodule
